// File: rtl/ssd_scan.sv
// Multiplexed common-anode seven-segment scanner with frame-synchronous double buffer.
// Optional leading-zero suppression is enabled by defining SSD_LZ_BLANK_EN.
module ssd_scan #(
  parameter int DIGITS      = 4,
  parameter int REFRESH_DIV = 100000,
  parameter int GUARD       = 16
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [4*DIGITS-1:0]   data,
  input  logic [DIGITS-1:0]     dp,
  input  logic [DIGITS-1:0]     blank,
  input  logic                  load,
  output logic [DIGITS-1:0]     an,
  output logic [6:0]            seg,
  output logic                  dp_n,
  output logic                  frame_done
);

  localparam int CW = $clog2(REFRESH_DIV);
  localparam int IW = (DIGITS > 1) ? $clog2(DIGITS) : 1;
  localparam logic [CW-1:0] CMAX  = CW'(REFRESH_DIV - 1);
  localparam logic [CW-1:0] CGRD  = CW'(GUARD);
  localparam logic [IW-1:0] ILAST = IW'(DIGITS - 1);

  logic [CW-1:0]       cnt;
  logic [IW-1:0]       idx;
  logic                pend;
  logic [4*DIGITS-1:0] p_data;
  logic [DIGITS-1:0]   p_dp;
  logic [DIGITS-1:0]   p_blank;
  logic [4*DIGITS-1:0] d_data;
  logic [DIGITS-1:0]   d_dp;
  logic [DIGITS-1:0]   d_blank;

  logic                dwell_end;
  logic                frame_end;
  logic [DIGITS-1:0]   lz;
  logic [3:0]          nib;
  logic                dark;
  logic [DIGITS-1:0]   an_d;

  function automatic logic [6:0] hex7(input logic [3:0] n);
    unique case (n)
      4'h0: return 7'b0000001;
      4'h1: return 7'b1001111;
      4'h2: return 7'b0010010;
      4'h3: return 7'b0000110;
      4'h4: return 7'b1001100;
      4'h5: return 7'b0100100;
      4'h6: return 7'b0100000;
      4'h7: return 7'b0001111;
      4'h8: return 7'b0000000;
      4'h9: return 7'b0000100;
      4'hA: return 7'b0001000;
      4'hB: return 7'b1100000;
      4'hC: return 7'b0110001;
      4'hD: return 7'b1000010;
      4'hE: return 7'b0110000;
      4'hF: return 7'b0111000;
    endcase
  endfunction

  assign dwell_end = (cnt == CMAX);
  assign frame_end = dwell_end && (idx == ILAST);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= '0;
      idx <= '0;
    end else if (dwell_end) begin
      cnt <= '0;
      idx <= (idx == ILAST) ? '0 : idx + 1'b1;
    end else begin
      cnt <= cnt + 1'b1;
    end
  end

  // A load on the frame-end cycle bypasses the pending buffer entirely.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pend    <= 1'b0;
      p_data  <= '0;
      p_dp    <= '0;
      p_blank <= '0;
      d_data  <= '0;
      d_dp    <= '0;
      d_blank <= '0;
    end else if (frame_end && load) begin
      d_data  <= data;
      d_dp    <= dp;
      d_blank <= blank;
      pend    <= 1'b0;
    end else if (frame_end && pend) begin
      d_data  <= p_data;
      d_dp    <= p_dp;
      d_blank <= p_blank;
      pend    <= 1'b0;
    end else if (load) begin
      p_data  <= data;
      p_dp    <= dp;
      p_blank <= blank;
      pend    <= 1'b1;
    end
  end

`ifdef SSD_LZ_BLANK_EN
  logic run;
  always_comb begin
    lz  = '0;
    run = 1'b1;
    for (int i = DIGITS - 1; i > 0; i--) begin
      if (run && d_data[4*i +: 4] == 4'h0 && !d_dp[i])
        lz[i] = 1'b1;
      else
        run = 1'b0;
    end
  end
`else
  assign lz = '0;
`endif

  assign nib  = d_data[4*int'(idx) +: 4];
  assign dark = d_blank[idx] | lz[idx];

  always_comb begin
    an_d = '1;
    if (cnt >= CGRD)
      an_d[idx] = 1'b0;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      an         <= '1;
      seg        <= 7'h7F;
      dp_n       <= 1'b1;
      frame_done <= 1'b0;
    end else begin
      an         <= an_d;
      seg        <= dark ? 7'h7F : hex7(nib);
      dp_n       <= dark ? 1'b1 : ~d_dp[idx];
      frame_done <= frame_end;
    end
  end

endmodule

// File: doc/ssd_scan.md
# ssd_scan

Time-multiplexed driver for a DIGITS-wide common-anode seven-segment display. It decodes one 4-bit hex nibble per digit, scans the digits at a programmable refresh rate, and inserts a guard interval with all anodes off between digits to suppress ghosting. Data is double-buffered and swapped only at frame boundaries, so a displayed frame never mixes old and new values. It sits between the processor debug taps (PC, register or ALU values) and the board's anode and segment pins.

## Interface
- DIGITS, 4: number of digits scanned, 1..8.
- REFRESH_DIV, 100000: dwell per digit in clk cycles, ≥ 4.
- GUARD, 16: leading cycles of each dwell with all anodes off, 1..REFRESH_DIV-2.

- clk  in  1  system clock.
- rst_n  in  1  asynchronous active-low reset.
- data  in  4*DIGITS  hex nibbles; data[3:0] is digit 0 (rightmost).
- dp  in  DIGITS  decimal-point request per digit, 1 = lit.
- blank  in  DIGITS  forces a digit dark, 1 = dark.
- load  in  1  single-cycle strobe that captures data, dp and blank.
- an  out  DIGITS  anode enables, active-low, at most one low.
- seg  out  7  segments {a,b,c,d,e,f,g}, active-low.
- dp_n  out  1  decimal point, active-low.
- frame_done  out  1  one-cycle pulse when the last digit's dwell ends.

## Operation
- State:
  - dwell counter cnt, 0..REFRESH_DIV-1.
  - digit index idx, 0..DIGITS-1.
  - pending buffer plus pend flag.
  - display buffer.
- Scanning:
  - cnt increments every cycle.
  - When cnt = REFRESH_DIV-1: cnt←0 and idx←idx+1, wrapping DIGITS-1→0.
- Load:
  - load captures data, dp and blank into the pending buffer and sets pend.
  - A second load before the swap overwrites the pending buffer. The last value wins.
- Swap:
  - Happens at the frame end, i.e. cnt = REFRESH_DIV-1 and idx = DIGITS-1.
  - If pend=1, the pending buffer is copied to the display buffer and pend is cleared.
  - If load coincides with the frame end, the inputs are written straight to the display buffer, pend←0 and the pending buffer is discarded.
- Decode of nibble n, seg value:
  - 0→0000001, 1→1001111, 2→0010010, 3→0000110
  - 4→1001100, 5→0100100, 6→0100000, 7→0001111
  - 8→0000000, 9→0000100, A→0001000, b→1100000
  - C→0110001, d→1000010, E→0110000, F→0111000
- Dark digit:
  - A digit is dark when its blank bit is set, or when suppressed (see Configuration).
  - A dark digit gives seg=1111111 and dp_n=1, but its anode still scans.
- Anode output: an[idx]=0 only while cnt ≥ GUARD. During the guard interval, an is all ones.

## Timing
- Outputs an, seg, dp_n and frame_done are registered.
  - Each reflects the state (cnt, idx, display buffer) of the previous cycle.
  - Latency from state to pin is 1 cycle.
- Per dwell, the active anode is low for exactly REFRESH_DIV-GUARD cycles.
- Frame period is DIGITS*REFRESH_DIV cycles.
- frame_done is high for the one cycle after the frame-end state.
- Load-to-display latency:
  - Minimum 1 cycle (load at the frame end).
  - Maximum DIGITS*REFRESH_DIV cycles.
- Reset values, applied immediately and asynchronously:
  - cnt=0, idx=0, pend=0, both buffers all zeros.
  - an all ones, seg=1111111, dp_n=1, frame_done=0.
- Reset deasserted mid-frame:
  - Scanning restarts at digit 0, cnt=0.
  - First anode low at the output on cycle GUARD+1 after release.
- Segment and dp outputs change only at dwell boundaries, while all anodes are off.

## Configuration
- SSD_LZ_BLANK_EN defined: leading-zero suppression.
  - Starting from digit DIGITS-1 and moving downward, each digit whose nibble is 0 and whose dp bit is 0 is dark.
  - Suppression stops at the first digit that fails that test.
  - Digit 0 is never suppressed.
  - Evaluated on the display buffer.
- SSD_LZ_BLANK_EN undefined: every non-blanked digit shows its nibble, including zeros.

## Test plan
Parameters for all scenarios: DIGITS=4, REFRESH_DIV=8, GUARD=2.

- Reset: hold rst_n=0 mid-scan → an=1111, seg=1111111, dp_n=1 in the same cycle. After release, an=1110 first appears on cycle 3.
- Scan: load data=16'h12AF once → per frame:
  - an walks 1110, 1101, 1011, 0111, each low 6 of 8 cycles.
  - seg goes 0111000, 0001000, 0010010, 1001111.
  - frame_done pulses every 32 cycles.
- Double buffer: load 16'h1111 mid-frame, then 16'h2222 before the frame end → the next frame shows only 2s, never a mix or a 1.
- Coincident load: load 16'h00E0 on the frame-end cycle → digit 1 shows seg=0110000 starting with the very next frame.
- Blank and dp: blank=0100, dp=0001, data=16'h8888 → digit 2 dark. Digit 0 shows seg=0000000 with dp_n=0.
- With SSD_LZ_BLANK_EN: data=16'h0050 → digits 3 and 2 dark, digit 1 shows 0100100, digit 0 shows 0000001. Without the macro, all four digits are lit.
